hazard_ctrl: RTL and testbench

- Pipeline hazard controller; drives the stall, clear and forwarding-select inputs of the ID/EX pipeline register.
- Keeps its own shadow copy of destination-register state for the EX and MEM stages.
- Detects RAW hazards, load-use hazards, taken branches/jumps and data-memory wait states.
- Sits beside the decoder in the ID stage and is the single source of all pipeline hold/bubble/flush controls.

---
 rtl/riscv_defines.sv | 27 ++
 rtl/hazard_fwd_cmp.sv | 19 +
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the ID-stage hazard controller: register index
// width, the memory-wait state encoding and the shadow pipeline-stage record.
package riscv_defines;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    // Destination info tracked for the EX and MEM stages.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      load;
    } stage_dst_t;

    // True when a source operand that is actually read matches a stage that
    // writes a non-zero destination register. x0 never carries a dependency.
    function automatic logic regMatch(input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input logic                      useRs,
                                      input stage_dst_t                dst);
        return useRs && (rs != '0) && dst.we && (dst.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Forwarding comparator for one source operand. type1 selects the EX-stage
// result, type2 the MEM-stage result; EX wins when both match because it
// holds the younger value. A load in EX has no result yet, so it never
// forwards from EX (that case is the load-use stall instead).
module hazard_fwd_cmp
    import riscv_defines::*;
(
    input  logic                      use_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  stage_dst_t                exDst_i,
    input  stage_dst_t                memDst_i,
    output logic                      type1_o,
    output logic                      type2_o
);

    assign type1_o = regMatch(rs_i, use_i, exDst_i) && !exDst_i.load;
    assign type2_o = regMatch(rs_i, use_i, memDst_i) && !type1_o;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline hazard controller. Tracks shadow destination state for
// EX and MEM, and produces every hold, bubble, flush and forwarding select
// for the ID/EX register, plus a data-memory wait FSM with timeout abort.
module hazard_ctrl
    import riscv_defines::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_use_rs1_i,
    input  logic                      id_use_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_write_en_i,
    input  logic                      id_load_i,
    input  logic                      ex_branch_taken_i,
    input  logic                      mem_access_i,
    input  logic                      dmem_ready_i,
    output logic                      fwrd_opA_type1_o,
    output logic                      fwrd_opA_type2_o,
    output logic                      fwrd_opB_type1_o,
    output logic                      fwrd_opB_type2_o,
    output logic                      stall_if_o,
    output logic                      stall_ctrl_o,
    output logic                      clear_ctrl_o,
    output logic                      flush_if_id_o,
    output logic                      stall_mem_o,
    output logic                      mem_timeout_o,
    output logic [CNT_WIDTH-1:0]      stall_count_o
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t        state_q, state_d;
    logic [WAIT_W-1:0]    waitCnt_q, waitCnt_d;
    logic                 timeoutFire;
    logic                 memTimeout_q;
    stage_dst_t           exDst_q, exDst_d;
    stage_dst_t           memDst_q, memDst_d;
    logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d;

    logic fwdA1, fwdA2, fwdB1, fwdB2;
    logic memStall;
    logic loadUse;

    hazard_fwd_cmp u_fwdA (
        .use_i    (id_use_rs1_i),
        .rs_i     (id_rs1_i),
        .exDst_i  (exDst_q),
        .memDst_i (memDst_q),
        .type1_o  (fwdA1),
        .type2_o  (fwdA2)
    );

    hazard_fwd_cmp u_fwdB (
        .use_i    (id_use_rs2_i),
        .rs_i     (id_rs2_i),
        .exDst_i  (exDst_q),
        .memDst_i (memDst_q),
        .type1_o  (fwdB1),
        .type2_o  (fwdB2)
    );

    // Memory-wait FSM register, wait counter and delayed timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            memTimeout_q <= timeoutFire;
        end
    end

    // Next state: enter MEM_WAIT on an unready access, leave on ready or after MEM_TIMEOUT wait cycles.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        timeoutFire = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_access_i && !dmem_ready_i) begin
                    state_d   = MEM_WAIT;
                    waitCnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d     = RUN;
                    waitCnt_d   = '0;
                    timeoutFire = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // Pipeline controls with priority memory stall > branch flush > load-use bubble.
    always_comb begin
        memStall = ((state_q == RUN) && mem_access_i && !dmem_ready_i) ||
                   ((state_q == MEM_WAIT) && !dmem_ready_i);
        loadUse  = exDst_q.load &&
                   (regMatch(id_rs1_i, id_use_rs1_i, exDst_q) ||
                    regMatch(id_rs2_i, id_use_rs2_i, exDst_q));

        fwrd_opA_type1_o = fwdA1;
        fwrd_opA_type2_o = fwdA2;
        fwrd_opB_type1_o = fwdB1;
        fwrd_opB_type2_o = fwdB2;
        stall_if_o       = 1'b0;
        stall_ctrl_o     = 1'b0;
        clear_ctrl_o     = 1'b0;
        flush_if_id_o    = 1'b0;
        stall_mem_o      = 1'b0;

        if (memStall) begin
            stall_if_o   = 1'b1;
            stall_ctrl_o = 1'b1;
            stall_mem_o  = 1'b1;
        end else if (ex_branch_taken_i) begin
            flush_if_id_o = 1'b1;
            clear_ctrl_o  = 1'b1;
        end else if (loadUse) begin
            stall_if_o       = 1'b1;
            clear_ctrl_o     = 1'b1;
            fwrd_opA_type1_o = 1'b0;
            fwrd_opA_type2_o = 1'b0;
            fwrd_opB_type1_o = 1'b0;
            fwrd_opB_type2_o = 1'b0;
        end
    end

    // Shadow next state follows the ID/EX and EX/MEM registers, including bubbles and the dropped access.
    always_comb begin
        exDst_d = exDst_q;
        if (!stall_ctrl_o) begin
            exDst_d.rd   = id_rd_i;
            exDst_d.we   = id_write_en_i && !clear_ctrl_o;
            exDst_d.load = id_load_i && !clear_ctrl_o;
        end
        memDst_d = memDst_q;
        if (!stall_mem_o) begin
            memDst_d = exDst_q;
        end
        if (timeoutFire) begin
            memDst_d.we = 1'b0;
        end
    end

    // Saturating count of cycles in which any hold or bubble is asserted.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if ((stall_if_o || stall_ctrl_o || clear_ctrl_o) && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
        end
    end

    // Shadow stage registers and the stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            exDst_q    <= '0;
            memDst_q   <= '0;
            stallCnt_q <= '0;
        end else begin
            exDst_q    <= exDst_d;
            memDst_q   <= memDst_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign mem_timeout_o = memTimeout_q;
    assign stall_count_o = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each step drives one cycle of inputs and
// pushes the expected control vector and stall count onto a scoreboard; the
// entry is popped and compared at the following falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, id_write_en_i, id_load_i;
    logic        ex_branch_taken_i, mem_access_i, dmem_ready_i;
    logic        fwrd_opA_type1_o, fwrd_opA_type2_o, fwrd_opB_type1_o, fwrd_opB_type2_o;
    logic        stall_if_o, stall_ctrl_o, clear_ctrl_o, flush_if_id_o, stall_mem_o, mem_timeout_o;
    logic [31:0] stall_count_o;

    // Control vector bit positions: {A1,A2,B1,B2,stall_if,stall_ctrl,clear,flush,stall_mem,timeout}
    localparam logic [9:0] NONE = 10'h000;
    localparam logic [9:0] A1   = 10'h200;
    localparam logic [9:0] A2   = 10'h100;
    localparam logic [9:0] B1   = 10'h080;
    localparam logic [9:0] SIF  = 10'h020;
    localparam logic [9:0] SCT  = 10'h010;
    localparam logic [9:0] CLR  = 10'h008;
    localparam logic [9:0] FLS  = 10'h004;
    localparam logic [9:0] SMEM = 10'h002;
    localparam logic [9:0] TMO  = 10'h001;
    localparam logic [9:0] MST  = SIF | SCT | SMEM;

    typedef struct {
        string       tag;
        logic [9:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          passCnt  = 0;
    int          checkCnt = 0;
    logic [31:0] modelCnt = '0;
    logic [9:0]  obsCtl;

    assign obsCtl = {fwrd_opA_type1_o, fwrd_opA_type2_o, fwrd_opB_type1_o, fwrd_opB_type2_o,
                     stall_if_o, stall_ctrl_o, clear_ctrl_o, flush_if_id_o, stall_mem_o, mem_timeout_o};

    hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .id_rd_i           (id_rd_i),
        .id_write_en_i     (id_write_en_i),
        .id_load_i         (id_load_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .mem_access_i      (mem_access_i),
        .dmem_ready_i      (dmem_ready_i),
        .fwrd_opA_type1_o  (fwrd_opA_type1_o),
        .fwrd_opA_type2_o  (fwrd_opA_type2_o),
        .fwrd_opB_type1_o  (fwrd_opB_type1_o),
        .fwrd_opB_type2_o  (fwrd_opB_type2_o),
        .stall_if_o        (stall_if_o),
        .stall_ctrl_o      (stall_ctrl_o),
        .clear_ctrl_o      (clear_ctrl_o),
        .flush_if_id_o     (flush_if_id_o),
        .stall_mem_o       (stall_mem_o),
        .mem_timeout_o     (mem_timeout_o),
        .stall_count_o     (stall_count_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and record what the DUT must show.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd, input logic we, input logic ld,
                                 input logic br, input logic macc, input logic rdy,
                                 input logic rstIn, input logic [9:0] expCtl);
        exp_t e;
        @(posedge clk);
        #1;
        id_rs1_i          = rs1;
        id_use_rs1_i      = u1;
        id_rs2_i          = rs2;
        id_use_rs2_i      = u2;
        id_rd_i           = rd;
        id_write_en_i     = we;
        id_load_i         = ld;
        ex_branch_taken_i = br;
        mem_access_i      = macc;
        dmem_ready_i      = rdy;
        rst               = rstIn;
        e.tag = tag;
        e.ctl = expCtl;
        e.cnt = modelCnt;
        sb.push_back(e);
        if ((expCtl & (SIF | SCT | CLR)) != NONE && modelCnt != '1) modelCnt = modelCnt + 1;
        if (rstIn) modelCnt = '0;
    endtask

    // Pop the oldest expectation and compare it against the DUT at the falling edge.
    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checkCnt++;
            $error("[TB] FAIL scoreboard: observed no entry, expected one queued");
            return;
        end
        e = sb.pop_front();
        checkCnt++;
        assert (obsCtl === e.ctl) passCnt++;
        else $error("[TB] FAIL %s ctl: observed %b expected %b", e.tag, obsCtl, e.ctl);
        checkCnt++;
        assert (stall_count_o === e.cnt) passCnt++;
        else $error("[TB] FAIL %s stall_count: observed %0d expected %0d", e.tag, stall_count_o, e.cnt);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed time limit, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_write_en_i = 1'b0; id_load_i = 1'b0;
        ex_branch_taken_i = 1'b0; mem_access_i = 1'b0; dmem_ready_i = 1'b1;
        repeat (3) @(posedge clk);

        //             tag                    rs1 u1 rs2 u2 rd we ld br ma rdy rst exp
        applyStimulus("reset idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("add x5",               0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("fwdA from EX",         5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A1);        checkOutput();
        applyStimulus("fwdA from MEM",        5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A2);        checkOutput();
        applyStimulus("add x7 first",         0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("add x7 second",        0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("fwdB EX priority",     0, 0, 7, 1, 0, 1, 0, 0, 0, 1, 0, B1);        checkOutput();
        applyStimulus("x0 no forward",        0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("lw x3",                0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("load-use bubble",      3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, SIF | CLR); checkOutput();
        applyStimulus("load fwd from MEM",    3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A2);        checkOutput();
        applyStimulus("lw x3 again",          0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("branch over load-use", 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, FLS | CLR); checkOutput();
        applyStimulus("after branch",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("wait entry",           0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST);       checkOutput();
        applyStimulus("wait 1 with branch",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, MST);       checkOutput();
        applyStimulus("wait 2 with branch",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, MST);       checkOutput();
        applyStimulus("ready then flush",     0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, FLS | CLR); checkOutput();
        applyStimulus("add x9",               0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("fwdA x9 from EX",      9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A1);        checkOutput();
        applyStimulus("timeout entry",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST);       checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("timeout wait %0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST);
            checkOutput();
        end
        applyStimulus("timeout pulse x9 drop",9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, TMO);       checkOutput();
        applyStimulus("timeout pulse ends",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE);      checkOutput();
        applyStimulus("rst wait entry",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST);       checkOutput();
        applyStimulus("rst wait 1",           0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST);       checkOutput();
        applyStimulus("rst at wait 2",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MST);       checkOutput();
        applyStimulus("after mid-wait rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);      checkOutput();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
